fpu_seq: RTL
============

Name: fpu_seq

Overview:
- Sequencer that lets the single-cycle ARM core share one multi-cycle FPU.
- When a condition-passed FP instruction is decoded, it stalls PC/fetch, issues the op to the FPU, and waits for completion. It then commits the register write and the FPU flag write in one cycle.
- Sits between the decoder/condition logic and the FPU. Drives the FPU flag-write enable and register-write enable into the flag registers and register file.

Parameters:
- TIMEOUT, 32, max WAIT cycles before the op is aborted (>=2).
- OP_W, 2, width of the FPU opcode field.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- FPOp  in  1  decoded instruction targets the FPU.
- CondEx  in  1  condition check passed for the current instruction.
- FPUOpIn  in  OP_W  decoded FPU operation.
- FPURegW  in  1  decoded: FP result writes the register file.
- FPUFlagWIn  in  2  decoded flag-write mask ([1]=NZ, [0]=CV).
- FPUDone  in  1  FPU result valid (one-cycle pulse).
- Stall  out  1  hold PC and fetch.
- FPUStart  out  1  one-cycle start pulse to the FPU.
- FPUOpOut  out  OP_W  latched opcode, stable from ISSUE through COMMIT.
- FPUAbort  out  1  one-cycle abort pulse on timeout.
- FPURegWrite  out  1  register-file write enable for the FP result.
- FPUFlagW  out  2  flag-register write enable mask.
- Busy  out  1  state != IDLE.
- Fault  out  1  sticky timeout indicator.
- StallCount  out  32  performance counter (see optional feature).

Behaviour:
- Reset (reset=0, async): state=IDLE, wait counter=0, latched op/RegW/FlagW=0, Fault=0, StallCount=0. Every output is 0 while reset is asserted, including Stall.
- States:
  - IDLE to ISSUE when FPOp & CondEx.
  - ISSUE to COMMIT if FPUDone, else to WAIT.
  - WAIT to COMMIT on FPUDone, or to ERR when counter == TIMEOUT-1 and !FPUDone.
  - COMMIT to IDLE.
  - ERR to IDLE.
- IDLE:
  - Stall = FPOp & CondEx (Mealy), so the PC does not advance on the issuing cycle.
  - On the transition to ISSUE, latch FPUOpIn, FPURegW and FPUFlagWIn.
  - FPOp & !CondEx: no stall; the instruction retires as a no-op.
- ISSUE: FPUStart=1 for exactly one cycle, Stall=1, counter cleared to 0.
- WAIT: Stall=1, counter +1 per cycle. If FPUDone and timeout occur in the same cycle, FPUDone wins.
- COMMIT (exactly one cycle):
  - Stall=0, so the PC advances at the next edge.
  - FPURegWrite = latched RegW.
  - FPUFlagW = latched FlagW mask. CondEx is not re-checked because it was qualified at issue.
- ERR (one cycle):
  - FPUAbort=1, Stall=0, no register or flag writes.
  - Fault set; it stays set until reset.
- FPUDone outside ISSUE/WAIT is ignored.
- FPUStart, FPUAbort, FPURegWrite and FPUFlagW are decoded from registered state; they never depend combinationally on inputs.
- Minimum FP instruction latency is 3 cycles (IDLE-issue, ISSUE, COMMIT). Latency is 3+N with N WAIT cycles.
- Back-to-back FP instructions: after COMMIT the next instruction is presented in IDLE and reissues with no bubble beyond IDLE.
- Reset mid-operation: immediate return to IDLE. The FPU is not sent an abort, because the FPU shares the same reset.

Optional Feature:
- Macro FPU_SEQ_PERF_EN.
- Defined: StallCount increments on every cycle with Stall=1. It saturates at 32'hFFFFFFFF and clears only on reset.
- Undefined: the counter is not instantiated and StallCount is tied to 0.

Decomposition:
- Package/header fpu_seq_defs: state encodings (IDLE, ISSUE, WAIT, COMMIT, ERR, 3-bit), FPU opcode constants (FADD, FMUL, FSUB, FDIV), flag-mask bit positions.
- One sub-module, fpu_seq_timer: clearable, enable-driven up-counter of width $clog2(TIMEOUT) with a terminal-count output. It is reused for the timeout path.

Test Plan:
- FPOp=1, CondEx=1, FPUOpIn=2'b01, FPURegW=1, FPUFlagWIn=2'b11; FPUDone after 4 WAIT cycles:
  - FPUStart pulses once and Stall is high for 6 cycles.
  - COMMIT shows FPURegWrite=1 and FPUFlagW=2'b11, then Busy=0.
- FPOp=1, CondEx=0: Stall, FPUStart, FPURegWrite and FPUFlagW all stay 0, and state stays IDLE.
- FPUDone asserted in the ISSUE cycle: WAIT is skipped, COMMIT comes at cycle 3 and Stall is high for exactly 2 cycles.
- FPUDone never asserted, TIMEOUT=32:
  - ERR is entered after 32 WAIT cycles and FPUAbort pulses once.
  - Fault=1 persists, no commit write occurs, then IDLE.
  - A later FPUDone and FPOp=0 do not change Fault.
- reset driven low during WAIT (counter=10): all outputs go to 0 immediately. After release the state is IDLE and counter=0.
- With FPU_SEQ_PERF_EN defined, run two ops with 4 and 0 WAIT cycles: StallCount=8. Without the macro, StallCount=0.

Source files
------------

// File: rtl/fpu_seq_defs.sv
// fpu_seq_defs: shared definitions for the FPU sequencer.
// Holds the 3-bit state encoding, the FPU opcode constants and the
// flag-write mask bit positions used by fpu_seq and its users.
package fpu_seq_defs;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_COMMIT = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  // FPU opcodes carried on FPUOpIn / FPUOpOut
  localparam logic [1:0] FADD = 2'd0;
  localparam logic [1:0] FMUL = 2'd1;
  localparam logic [1:0] FSUB = 2'd2;
  localparam logic [1:0] FDIV = 2'd3;

  // bit positions inside the 2-bit flag-write mask
  localparam int FLAG_NZ = 1;
  localparam int FLAG_CV = 0;

endpackage

// File: rtl/fpu_seq_timer.sv
// fpu_seq_timer: clearable, enable-driven up-counter used as the FPU wait timeout.
// Ports: clk, reset (async, active low), clr (sync clear), en (count enable),
//        tc (count has reached TIMEOUT-1; the counter holds there).
module fpu_seq_timer #(
  parameter int TIMEOUT = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [CW-1:0] cnt;

  assign tc = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fpu_seq.sv
// fpu_seq: sequences one multi-cycle FPU op for a single-cycle core.
// Inputs : clk, reset (async, active low), FPOp, CondEx, FPUOpIn, FPURegW, FPUFlagWIn, FPUDone.
// Outputs: Stall, FPUStart, FPUOpOut, FPUAbort, FPURegWrite, FPUFlagW, Busy, Fault, StallCount.
// Optional: define FPU_SEQ_PERF_EN to build the saturating stall-cycle counter on StallCount.
module fpu_seq
  import fpu_seq_defs::*;
#(
  parameter int TIMEOUT = 32,
  parameter int OP_W    = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            FPOp,
  input  logic            CondEx,
  input  logic [OP_W-1:0] FPUOpIn,
  input  logic            FPURegW,
  input  logic [1:0]      FPUFlagWIn,
  input  logic            FPUDone,
  output logic            Stall,
  output logic            FPUStart,
  output logic [OP_W-1:0] FPUOpOut,
  output logic            FPUAbort,
  output logic            FPURegWrite,
  output logic [1:0]      FPUFlagW,
  output logic            Busy,
  output logic            Fault,
  output logic [31:0]     StallCount
);

  state_t          state;
  logic [OP_W-1:0] op_q;
  logic            regw_q;
  logic [1:0]      flagw_q;
  logic            start_q;
  logic            abort_q;
  logic            regwrite_q;
  logic [1:0]      flagw_out_q;
  logic            fault_q;
  logic            issue;
  logic            tmo;

  assign issue = FPOp & CondEx;

  // Counter is zeroed during ISSUE so the first WAIT cycle sees 0.
  fpu_seq_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state == S_ISSUE),
    .en    (state == S_WAIT),
    .tc    (tmo)
  );

  // Pulse outputs are registered alongside the transition that enters
  // the state they belong to, so they are pure flop outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      op_q        <= '0;
      regw_q      <= 1'b0;
      flagw_q     <= 2'b00;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      flagw_out_q <= 2'b00;
      fault_q     <= 1'b0;
    end else begin
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      flagw_out_q <= 2'b00;
      case (state)
        S_IDLE: begin
          if (issue) begin
            state   <= S_ISSUE;
            op_q    <= FPUOpIn;
            regw_q  <= FPURegW;
            flagw_q <= FPUFlagWIn;
            start_q <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (FPUDone) begin
            state       <= S_COMMIT;
            regwrite_q  <= regw_q;
            flagw_out_q <= flagw_q;
          end else begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // a completion arriving on the timeout cycle still commits
          if (FPUDone) begin
            state       <= S_COMMIT;
            regwrite_q  <= regw_q;
            flagw_out_q <= flagw_q;
          end else if (tmo) begin
            state   <= S_ERR;
            abort_q <= 1'b1;
            fault_q <= 1'b1;
          end
        end
        S_COMMIT: state <= S_IDLE;
        S_ERR:    state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // Stall is Mealy in IDLE so the PC holds on the issuing cycle; gated
  // by reset so it is 0 while reset is held even with FPOp&CondEx high.
  assign Stall = reset & (((state == S_IDLE) & issue) |
                          (state == S_ISSUE) | (state == S_WAIT));

  assign FPUStart    = start_q;
  assign FPUAbort    = abort_q;
  assign FPURegWrite = regwrite_q;
  assign FPUFlagW    = flagw_out_q;
  assign FPUOpOut    = op_q;
  assign Busy        = (state != S_IDLE);
  assign Fault       = fault_q;

`ifdef FPU_SEQ_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
    end else if (Stall && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign StallCount = stall_cnt;
`else
  assign StallCount = 32'd0;
`endif

endmodule
